bp_fe_ras: RTL

- Return-address stack for the front end. Sits directly downstream of the instruction scan stage and consumes its call/ret flags.
- On a call, it pushes the sequential return address. On a ret, it supplies the predicted target and pops.
- Speculative state can be checkpointed and restored when the backend redirects fetch.

---
 rtl/bp_fe_ras.sv | 97 +++++++++
 1 files changed

// File: rtl/bp_fe_ras.sv
// Return-address stack for the fetch front end.
// A call pushes pc+4 and a ret pops the top entry. The {cnt, ptr} state can be
// saved through ckpt_o and reloaded through restore_ckpt_i when fetch is redirected.
// The entries themselves are never checkpointed, so a restore after an
// overwrite can give a stale target. That is acceptable for a predictor.
module bp_fe_ras #(
  parameter  int vaddr_width_p = 39,
  parameter  int ras_els_p     = 8,
  localparam int ptr_width_lp  = $clog2(ras_els_p),
  localparam int cnt_width_lp  = $clog2(ras_els_p + 1),
  localparam int ckpt_width_lp = ptr_width_lp + cnt_width_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic                     call_i,
  input  logic                     ret_i,
  output logic                     tgt_v_o,
  output logic [vaddr_width_p-1:0] tgt_o,
  output logic [ckpt_width_lp-1:0] ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

  logic [vaddr_width_p-1:0] mem_q [ras_els_p];
  logic [ptr_width_lp-1:0]  ptr_q, ptr_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;

  logic                     mem_we;
  logic [ptr_width_lp-1:0]  mem_waddr;
  logic [vaddr_width_p-1:0] ret_addr;

  // Return address of an uncompressed call; it wraps at the top of the address space.
  assign ret_addr = pc_i + vaddr_width_p'(4);

  // Next-state selection: restore wins over push/pop; otherwise decode call/ret.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the branches can leave one unassigned and infer a latch.
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;

    if (restore_v_i) begin
      {cnt_d, ptr_d} = restore_ckpt_i;
    end else if (v_i) begin
      unique case ({call_i, ret_i})
        2'b10: begin
          // Push. When the stack is full, the oldest slot is overwritten.
          ptr_d     = ptr_q + 1'b1;
          mem_we    = 1'b1;
          mem_waddr = ptr_q + 1'b1;
          cnt_d     = (cnt_q == cnt_width_lp'(ras_els_p)) ? cnt_q : cnt_q + 1'b1;
        end
        2'b01: begin
          // Pop. A pop from an empty stack is dropped.
          if (cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end
        2'b11: begin
          // Coroutine swap: replace the top entry in place.
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          if (cnt_q == '0) cnt_d = cnt_width_lp'(1);
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage. A write is suppressed in a reset cycle, because reset takes priority.
  always_ff @(posedge clk_i) begin
    // NOTE: the array is deliberately left unreset. cnt==0 already marks every entry invalid, and an unreset array can map to RAM.
    if (reset_n_i && mem_we) mem_q[mem_waddr] <= ret_addr;
  end

  // Outputs come only from registered state.
  assign tgt_v_o = (cnt_q != '0);
  assign tgt_o   = tgt_v_o ? mem_q[ptr_q] : '0;
  assign ckpt_o  = {cnt_q, ptr_q};

endmodule
